lift_xfer_ctrl: RTL and testbench
=================================

Name: lift_xfer_ctrl

Overview:
- Sequencer and arbiter for the 240-bit lift port of the 2048-entry dual-bank coefficient memory.
- Accepts one bulk command: read or write of N consecutive lift rows, 4x60-bit coefficients per row.
- Waits until both NTT cores report idle, then seizes the memory by asserting lift_interrupt.
- Streams rows between the memory and valid/ready stream ports, then releases the memory and pulses done.

Parameters:
- FIFO_DEPTH, 4, read-return buffer entries; must be >=3 to sustain 1 row/cycle; power of two.
- LEN_W, 10, width of cmd_len; maximum length is 512.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = stream->memory, 0 = memory->stream
- cmd_base  in  9  first lift row
- cmd_len  in  LEN_W  number of rows, 0..512
- cores_idle  in  1  both cores idle; memory may be seized
- lift_interrupt  out  1  registered memory-ownership flag
- lift_address  out  9  current row
- lift_we  out  1  write strobe
- lift_wr_data  out  240  write row
- lift_rd_data  in  240  read row, valid 1 cycle after lift_address
- s_valid / s_ready / s_data  in/out/in  1/1/240  write stream
- m_valid / m_ready / m_data  out/in/out  1/1/240  read stream
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; all counters 0; FIFO empty; lift_interrupt=0, lift_we=0, lift_address=0, m_valid=0, s_ready=0, done=0, busy=0.
- Reset asserted mid-transfer aborts immediately. FIFO contents and pending rows are discarded.
- Command is accepted on cmd_valid&&cmd_ready and latches write, base and len.
- len=0: go straight to DONE; lift_interrupt never asserts.
- States:
  - IDLE: on accept, go to GRANT, or to DONE if len=0.
  - GRANT: when cores_idle=1, set lift_interrupt=1 and go to XFER. Wait indefinitely otherwise.
  - XFER, write: s_ready=1. lift_we = s_valid; lift_wr_data = s_data; lift_address = addr (combinational). Each handshake increments addr and cnt. When cnt reaches len, go to DONE.
  - XFER, read: issue a row when cnt<len and (fifo_count + inflight) < FIFO_DEPTH. inflight is a registered 1-bit flag "issued last cycle". When inflight=1, push lift_rd_data into the FIFO. After the last row is issued, go to DRAIN.
  - DRAIN: wait for inflight=0 and FIFO empty (last m handshake), then go to DONE.
  - DONE: done=1 for one cycle; lift_interrupt cleared; return to IDLE.
- lift_interrupt is held continuously from GRANT exit until DONE. cores_idle dropping mid-transfer is ignored; ownership is never revoked.
- Address arithmetic is 9-bit and wraps 511->0. Example: base=510, len=4 gives rows 510, 511, 0, 1.
- Read latency: address in cycle T; data captured at end of T+1; m_valid in T+2.
- Throughput is 1 row/cycle with m_ready=1 and FIFO_DEPTH>=3.
- Simultaneous FIFO push and pop in one cycle are both legal; count is unchanged.
- m_data is stable while m_valid && !m_ready.
- lift_address holds its last value when idle; lift_we=0 outside XFER.

Optional Feature:
- LIFT_XFER_STATS_EN:
  - When defined, adds output stall_cycles[15:0], a saturating count of cycles in GRANT or XFER/DRAIN with no beat moved.
  - The count clears on command accept and is held after done.
  - When not defined, the port and logic are absent.

Decomposition:
- Shared package: state encoding (IDLE, GRANT, XFER, DRAIN, DONE), LIFT_ROW_W=240, LIFT_ADDR_W=9, LIFT_ROWS=512.
- One sub-module: lift_xfer_fifo, a synchronous FIFO_DEPTH x 240 buffer with registered outputs and a count output.

Test Plan:
- Write base=0, len=512, cores_idle=1, s_valid always 1 -> 512 lift_we pulses at addresses 0..511, one per cycle. done arrives 1 cycle after the last beat; lift_interrupt drops with done.
- Read base=510, len=4, m_ready=1 -> lift_address sequence 510, 511, 0, 1. m_data equals the preloaded rows in the same order. First m_valid arrives 2 cycles after the first address.
- Read len=8 with m_ready toggling 1,0,0,1 -> no lost or duplicated rows. fifo_count never exceeds FIFO_DEPTH; m_data is stable during stalls.
- cores_idle=0 for 20 cycles after accept -> lift_interrupt stays 0 and busy=1 throughout. lift_interrupt rises the cycle after cores_idle=1.
- len=0 -> done 1 cycle after accept; lift_interrupt never rises.
- rst_n low mid-read (cnt=100) -> all outputs return to reset values immediately. A new command is accepted after reset release.

Source files
------------

// File: rtl/lift_xfer_ctrl_pkg.sv
// Shared types and constants for the lift-port transfer controller.
package lift_xfer_ctrl_pkg;

    localparam int LIFT_ROW_W  = 240;
    localparam int LIFT_ADDR_W = 9;
    localparam int LIFT_ROWS   = 512;

    typedef logic [LIFT_ROW_W-1:0]  lift_row_t;
    typedef logic [LIFT_ADDR_W-1:0] lift_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_XFER,
        ST_DRAIN,
        ST_DONE
    } xfer_state_e;

endpackage

// File: rtl/lift_xfer_ctrl_if.sv
// Command, memory-port and stream signals of the lift transfer controller.
// stall_cycles exists only when LIFT_XFER_STATS_EN is defined.
interface lift_xfer_ctrl_if #(parameter int LEN_W = 10);
    import lift_xfer_ctrl_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    lift_addr_t       cmd_base;
    logic [LEN_W-1:0] cmd_len;
    logic             cores_idle;

    logic             lift_interrupt;
    lift_addr_t       lift_address;
    logic             lift_we;
    lift_row_t        lift_wr_data;
    lift_row_t        lift_rd_data;

    logic             s_valid;
    logic             s_ready;
    lift_row_t        s_data;
    logic             m_valid;
    logic             m_ready;
    lift_row_t        m_data;

    logic             busy;
    logic             done;
`ifdef LIFT_XFER_STATS_EN
    logic [15:0]      stall_cycles;
`endif

    modport master (
`ifdef LIFT_XFER_STATS_EN
        output stall_cycles,
`endif
        input  cmd_valid, cmd_write, cmd_base, cmd_len, cores_idle,
        input  lift_rd_data, s_valid, s_data, m_ready,
        output cmd_ready, lift_interrupt, lift_address, lift_we, lift_wr_data,
        output s_ready, m_valid, m_data, busy, done
    );

    modport slave (
`ifdef LIFT_XFER_STATS_EN
        input  stall_cycles,
`endif
        output cmd_valid, cmd_write, cmd_base, cmd_len, cores_idle,
        output lift_rd_data, s_valid, s_data, m_ready,
        input  cmd_ready, lift_interrupt, lift_address, lift_we, lift_wr_data,
        input  s_ready, m_valid, m_data, busy, done
    );

endinterface

// File: rtl/lift_xfer_fifo.sv
// Read-return buffer: DEPTH rows of registered storage, show-ahead head, occupancy count.
module lift_xfer_fifo
    import lift_xfer_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  lift_row_t                  i_data,
    input  logic                       i_pop,
    output lift_row_t                  o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    lift_row_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/lift_xfer_ctrl.sv
// Lift-port bulk transfer sequencer: seizes the coefficient memory once both cores
// are idle and streams N rows in either direction. Optional macro: LIFT_XFER_STATS_EN.
//
//   state | meaning
//   IDLE  | waiting for a command
//   GRANT | command latched, waiting for cores_idle
//   XFER  | memory owned, rows moving (write: stream->mem, read: issuing reads)
//   DRAIN | read: all rows issued, emptying the return path
//   DONE  | one-cycle completion, ownership released
module lift_xfer_ctrl
    import lift_xfer_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 10
)(
    input  logic              clk,
    input  logic              rst_n,
    lift_xfer_ctrl_if.master  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    xfer_state_e      r_state;
    logic             r_write;
    lift_addr_t       r_addr;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic             r_inflight;
    logic             r_lift_int;

    logic             w_accept;
    logic             w_wr_beat;
    logic             w_issue;
    logic             w_pop;
    logic             w_drained;
    logic             w_last;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;
    logic [CNT_W:0]   w_occ;
    lift_row_t        w_fifo_data;

    assign w_accept  = bus.cmd_valid && (r_state == ST_IDLE);
    assign w_wr_beat = (r_state == ST_XFER) && r_write && bus.s_valid;
    assign w_occ     = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_issue   = (r_state == ST_XFER) && !r_write && (r_cnt < r_len)
                       && (w_occ < (CNT_W+1)'(FIFO_DEPTH));
    assign w_pop     = !w_fifo_empty && bus.m_ready;
    assign w_last    = ((r_cnt + LEN_W'(1)) == r_len);
    // Leave DRAIN on the cycle of the final stream handshake, not one after it.
    assign w_drained = !r_inflight
                       && (w_fifo_empty || ((w_fifo_count == CNT_W'(1)) && w_pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_inflight <= 1'b0;
            r_lift_int <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write <= bus.cmd_write;
                        r_addr  <= bus.cmd_base;
                        r_len   <= bus.cmd_len;
                        r_cnt   <= '0;
                        r_state <= (bus.cmd_len == '0) ? ST_DONE : ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (bus.cores_idle) begin
                        r_lift_int <= 1'b1;
                        r_state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_wr_beat || w_issue) begin
                        r_addr <= r_addr + LIFT_ADDR_W'(1);
                        r_cnt  <= r_cnt + LEN_W'(1);
                        if (w_last) begin
                            if (r_write) begin
                                r_state    <= ST_DONE;
                                r_lift_int <= 1'b0;
                            end else begin
                                r_state    <= ST_DRAIN;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_drained) begin
                        r_state    <= ST_DONE;
                        r_lift_int <= 1'b0;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    lift_xfer_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_data  (bus.lift_rd_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    assign bus.cmd_ready      = (r_state == ST_IDLE);
    assign bus.lift_interrupt = r_lift_int;
    assign bus.lift_address   = r_addr;
    assign bus.lift_we        = w_wr_beat;
    assign bus.lift_wr_data   = bus.s_data;
    assign bus.s_ready        = (r_state == ST_XFER) && r_write;
    assign bus.m_valid        = !w_fifo_empty;
    assign bus.m_data         = w_fifo_data;
    assign bus.busy           = (r_state != ST_IDLE);
    assign bus.done           = (r_state == ST_DONE);

`ifdef LIFT_XFER_STATS_EN
    logic [15:0] r_stall_cycles;
    logic        w_stall;

    assign w_stall = ((r_state == ST_GRANT) || (r_state == ST_XFER) || (r_state == ST_DRAIN))
                     && !(w_wr_beat || w_issue || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_accept) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_lift_xfer_ctrl.sv
// Directed bench for lift_xfer_ctrl with a behavioural 512-row synchronous memory.
module tb_lift_xfer_ctrl;
    import lift_xfer_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    lift_xfer_ctrl_if #(.LEN_W(10)) bus ();

    lift_xfer_ctrl #(.FIFO_DEPTH(4), .LEN_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    lift_row_t mem [0:511];
    always @(posedge clk) begin
        if (bus.lift_we) mem[bus.lift_address] <= bus.lift_wr_data;
        bus.lift_rd_data <= mem[bus.lift_address];
    end

    function automatic lift_row_t row_pat(input int n);
        return {60'(n*4+3), 60'(n*4+2), 60'(n*4+1), 60'(n*4)} ^ {4{60'hF0E1D2C3B4A5968}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int        k;
    logic      seen_done;
    logic      prev_stall;
    lift_row_t prev_data;
    int        exp_addr [4] = '{510, 511, 0, 1};

    initial begin
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_base = '0; bus.cmd_len = '0;
        bus.cores_idle = 0; bus.s_valid = 0; bus.s_data = '0; bus.m_ready = 0;

        // reset values
        step(); step();
        chk("rst_int", bus.lift_interrupt, 0);
        chk("rst_we", bus.lift_we, 0);
        chk("rst_addr", bus.lift_address, 0);
        chk("rst_mvalid", bus.m_valid, 0);
        chk("rst_sready", bus.s_ready, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        @(negedge clk); rst_n = 1;

        // full-memory write, one beat per cycle
        @(negedge clk);
        bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_base = 9'd0; bus.cmd_len = 10'd512;
        bus.cores_idle = 1; bus.s_valid = 1; bus.s_data = row_pat(0);
        #1 chk("wr_accept_ready", bus.cmd_ready, 1);
        @(negedge clk); bus.cmd_valid = 0; #1;
        chk("wr_grant_busy", bus.busy, 1);
        chk("wr_grant_we", bus.lift_we, 0);
        chk("wr_grant_int", bus.lift_interrupt, 0);
        for (int i = 0; i < 512; i++) begin
            @(negedge clk); bus.s_data = row_pat(i); #1;
            chk("wr_we", bus.lift_we, 1);
            chk("wr_addr", bus.lift_address, i);
            chk("wr_data", bus.lift_wr_data, row_pat(i));
            chk("wr_int", bus.lift_interrupt, 1);
        end
        @(negedge clk); bus.s_valid = 0; #1;
        chk("wr_done", bus.done, 1);
        chk("wr_done_int", bus.lift_interrupt, 0);
        chk("wr_done_we", bus.lift_we, 0);
        step();
        chk("wr_after_done", bus.done, 0);
        chk("wr_after_busy", bus.busy, 0);

        // read with 9-bit address wrap
        @(negedge clk);
        bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_base = 9'd510; bus.cmd_len = 10'd4;
        bus.m_ready = 1;
        #1 chk("rd_accept_ready", bus.cmd_ready, 1);
        @(negedge clk); bus.cmd_valid = 0; #1;
        chk("rd_grant_int", bus.lift_interrupt, 0);
        for (int c = 2; c <= 7; c++) begin
            step();
            chk("rd_int", bus.lift_interrupt, 1);
            if (c <= 5) chk("rd_addr", bus.lift_address, exp_addr[c-2]);
            chk("rd_mvalid", bus.m_valid, (c >= 4));
            if (c >= 4) chk("rd_mdata", bus.m_data, row_pat(exp_addr[c-4]));
        end
        step();
        chk("rd_done", bus.done, 1);
        chk("rd_done_int", bus.lift_interrupt, 0);
        chk("rd_done_mvalid", bus.m_valid, 0);

        // read of 8 rows with back-pressure 1,0,0,1
        @(negedge clk);
        bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_base = 9'd100; bus.cmd_len = 10'd8;
        #1 chk("rd8_accept_ready", bus.cmd_ready, 1);
        k = 0; seen_done = 0; prev_stall = 0; prev_data = '0;
        for (int cyc = 0; cyc < 100 && !seen_done; cyc++) begin
            @(negedge clk);
            bus.cmd_valid = 0;
            bus.m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            #1;
            if (prev_stall) begin
                chk("rd8_stall_valid", bus.m_valid, 1);
                chk("rd8_stall_data", bus.m_data, prev_data);
            end
            chk("rd8_fifo_bound", (dut.w_fifo_count <= 3'd4), 1);
            if (bus.m_valid && bus.m_ready) begin
                chk("rd8_data", bus.m_data, row_pat(100 + k));
                k++;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            if (bus.done) seen_done = 1;
        end
        chk("rd8_rows", k, 8);
        chk("rd8_done_seen", seen_done, 1);
        bus.m_ready = 1;
        step();
        chk("rd8_idle", bus.busy, 0);

        // grant held off by busy cores; ownership survives cores_idle dropping
        @(negedge clk);
        bus.cores_idle = 0; bus.cmd_valid = 1; bus.cmd_write = 1;
        bus.cmd_base = 9'd5; bus.cmd_len = 10'd2;
        #1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); bus.cmd_valid = 0; #1;
            chk("grant_wait_int", bus.lift_interrupt, 0);
            chk("grant_wait_busy", bus.busy, 1);
        end
        @(negedge clk); bus.cores_idle = 1; #1;
        chk("grant_edge_int", bus.lift_interrupt, 0);
        @(negedge clk); bus.s_valid = 1; bus.s_data = row_pat(5); #1;
        chk("grant_rise_int", bus.lift_interrupt, 1);
        chk("grant_we0", bus.lift_we, 1);
        chk("grant_addr0", bus.lift_address, 5);
        bus.cores_idle = 0;
        @(negedge clk); bus.s_data = row_pat(6); #1;
        chk("grant_held_int", bus.lift_interrupt, 1);
        chk("grant_addr1", bus.lift_address, 6);
        @(negedge clk); bus.s_valid = 0; #1;
        chk("grant_done", bus.done, 1);
        chk("grant_done_int", bus.lift_interrupt, 0);
        bus.cores_idle = 1;
        step();
        chk("grant_idle", bus.busy, 0);

        // zero-length command
        @(negedge clk);
        bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_len = 10'd0;
        #1 chk("len0_accept_ready", bus.cmd_ready, 1);
        @(negedge clk); bus.cmd_valid = 0; #1;
        chk("len0_done", bus.done, 1);
        chk("len0_int", bus.lift_interrupt, 0);
        step();
        chk("len0_after_done", bus.done, 0);
        chk("len0_after_busy", bus.busy, 0);
        chk("len0_after_int", bus.lift_interrupt, 0);

        // reset in the middle of a long read
        @(negedge clk);
        bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_base = 9'd0; bus.cmd_len = 10'd200;
        bus.m_ready = 1;
        for (int c = 1; c <= 102; c++) begin
            @(negedge clk); bus.cmd_valid = 0;
        end
        #1;
        chk("abort_pre_addr", bus.lift_address, 100);
        chk("abort_pre_mvalid", bus.m_valid, 1);
        rst_n = 0;
        #1;
        chk("abort_int", bus.lift_interrupt, 0);
        chk("abort_addr", bus.lift_address, 0);
        chk("abort_mvalid", bus.m_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_we", bus.lift_we, 0);
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_base = 9'd3; bus.cmd_len = 10'd1;
        bus.s_valid = 1; bus.s_data = row_pat(3);
        #1 chk("post_rst_ready", bus.cmd_ready, 1);
        @(negedge clk); bus.cmd_valid = 0; #1;
        chk("post_rst_grant_busy", bus.busy, 1);
        step();
        chk("post_rst_we", bus.lift_we, 1);
        chk("post_rst_addr", bus.lift_address, 3);
        @(negedge clk); bus.s_valid = 0; #1;
        chk("post_rst_done", bus.done, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
